pipelined_add_sub: RTL

- Parametrised successor to the team's single-bit full adder.
- Adds or subtracts two WIDTH-bit operands through a carry-chain pipeline of STAGES register slices.
- Each slice resolves one CHUNK = WIDTH/STAGES bit group and passes its carry to the next slice.
- A valid/ready handshake on both sides lets it sit inside the lab datapaths, behind operand registers and ahead of display/accumulator logic.

---
 rtl/pipelined_add_sub_if.sv | 30 +++
 rtl/pipelined_add_sub.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/pipelined_add_sub_if.sv
// Handshake and data bundle for pipelined_add_sub.
// The master side drives operands and consumes results; the slave side is the adder.
interface pipelined_add_sub_if #(
  parameter int WIDTH = 16
);
  // Operand side
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             cin;

  // Result side
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             overflow;

  modport master (
    output in_valid, a, b, sub, cin, out_ready,
    input  in_ready, out_valid, sum, cout, overflow
  );

  modport slave (
    input  in_valid, a, b, sub, cin, out_ready,
    output in_ready, out_valid, sum, cout, overflow
  );
endinterface

// File: rtl/pipelined_add_sub.sv
// Pipelined WIDTH-bit adder/subtractor built as a carry chain of STAGES slices.
// Slice k resolves bits [k*CHUNK +: CHUNK]. Slice 0 works directly on the
// incoming operands; each later slice works on skew registers that carry the
// still-unconsumed upper operand bits, the completed low sum bits and the
// carry from the previous slice. The last slice feeds the output register, so
// a result is presented STAGES edges after it was accepted.
// All stages share one advance enable: the whole pipe moves when the output
// is empty or being consumed, and freezes otherwise.
module pipelined_add_sub #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic               clk,
  input  logic               reset,
  pipelined_add_sub_if.slave bus
);

  localparam int CHUNK = WIDTH / STAGES;
  localparam int MSB   = WIDTH - 1;

  // Elaboration-time parameter sanity checks
  if (WIDTH < 2) begin : g_chk_width
    $error("pipelined_add_sub: WIDTH must be at least 2");
  end
  if (STAGES < 1) begin : g_chk_stages
    $error("pipelined_add_sub: STAGES must be at least 1");
  end
  if ((WIDTH % STAGES) != 0) begin : g_chk_chunk
    $error("pipelined_add_sub: WIDTH must be a multiple of STAGES");
  end

  // Output register
  logic             out_valid_reg;
  logic [WIDTH-1:0] sum_reg;
  logic             cout_reg;
  logic             overflow_reg;

  // Global advance: the pipe moves whenever the output slot is free or leaving
  logic adv;
  assign adv = !out_valid_reg || bus.out_ready;

  // Operand preparation: subtraction is A + ~B + 1
  logic [WIDTH-1:0] ent_a;
  logic [WIDTH-1:0] ent_b;
  logic             ent_c;

  assign ent_a = bus.a;
  assign ent_b = bus.sub ? ~bus.b : bus.b;
  assign ent_c = bus.sub | bus.cin;

  genvar gi;
  for (gi = 0; gi < STAGES; gi++) begin : g_stage
    localparam int LO = gi * CHUNK;

    // Inputs to slice gi: remaining operand bits, incoming carry, valid
    logic [WIDTH-1:LO]      a_src;
    logic [WIDTH-1:LO]      b_src;
    logic                   c_src;
    logic                   v_src;
    // Slice result: CHUNK sum bits plus carry-out in the top bit
    logic [CHUNK:0]         part;
    // All sum bits resolved so far, including this slice
    logic [LO+CHUNK-1:0]    s_out;
    logic                   c_out;

    if (gi == 0) begin : g_in
      // First slice works straight off the prepared operands
      assign a_src = ent_a;
      assign b_src = ent_b;
      assign c_src = ent_c;
      assign v_src = bus.in_valid;
      assign s_out = part[CHUNK-1:0];
    end else begin : g_in
      logic [WIDTH-1:LO] a_reg;
      logic [WIDTH-1:LO] b_reg;
      logic [LO-1:0]     s_reg;
      logic              c_reg;
      logic              v_reg;

      // Skew registers between slice gi-1 and slice gi; bubbles leave data untouched
      always_ff @(posedge clk) begin
        if (reset) begin
          a_reg <= '0;
          b_reg <= '0;
          s_reg <= '0;
          c_reg <= 1'b0;
          v_reg <= 1'b0;
        end else if (adv) begin
          v_reg <= g_stage[gi-1].v_src;
          if (g_stage[gi-1].v_src) begin
            a_reg <= g_stage[gi-1].a_src[WIDTH-1:LO];
            b_reg <= g_stage[gi-1].b_src[WIDTH-1:LO];
            s_reg <= g_stage[gi-1].s_out;
            c_reg <= g_stage[gi-1].c_out;
          end
        end
      end

      assign a_src = a_reg;
      assign b_src = b_reg;
      assign c_src = c_reg;
      assign v_src = v_reg;
      assign s_out = {part[CHUNK-1:0], s_reg};
    end

    // Chunk adder for this slice
    assign part  = {1'b0, a_src[LO +: CHUNK]}
                 + {1'b0, b_src[LO +: CHUNK]}
                 + {{CHUNK{1'b0}}, c_src};
    assign c_out = part[CHUNK];
  end

  // Final slice results gathered for the output register
  logic             fin_valid;
  logic [WIDTH-1:0] fin_sum;
  logic             fin_cout;
  logic             fin_a_msb;
  logic             fin_b_msb;
  logic             fin_ovf;

  assign fin_valid = g_stage[STAGES-1].v_src;
  assign fin_sum   = g_stage[STAGES-1].s_out;
  assign fin_cout  = g_stage[STAGES-1].c_out;
  assign fin_a_msb = g_stage[STAGES-1].a_src[MSB];
  assign fin_b_msb = g_stage[STAGES-1].b_src[MSB];
  // Signed overflow: like-signed operands producing a result of the other sign
  assign fin_ovf   = (fin_a_msb == fin_b_msb) && (fin_sum[MSB] != fin_a_msb);

  // Output register: holds while stalled, keeps last data across bubbles
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_reg <= 1'b0;
      sum_reg       <= '0;
      cout_reg      <= 1'b0;
      overflow_reg  <= 1'b0;
    end else if (adv) begin
      out_valid_reg <= fin_valid;
      if (fin_valid) begin
        sum_reg      <= fin_sum;
        cout_reg     <= fin_cout;
        overflow_reg <= fin_ovf;
      end
    end
  end

  assign bus.in_ready  = adv;
  assign bus.out_valid = out_valid_reg;
  assign bus.sum       = sum_reg;
  assign bus.cout      = cout_reg;
  assign bus.overflow  = overflow_reg;

endmodule
